sprite_motion: RTL and testbench

- Per-frame position generator for N independent sprites. Each sprite moves in X and Y with its own speed and edge mode: bounce or wrap.
- After each frame pulse, a small FSM updates the channels serially, one channel per clock.
- Sits between the display timing generator (frame strobe) and the sprite renderers. It drives their sprx/spry inputs.

---
 rtl/sprite_motion.sv | 192 +++++++++++++++++++
 tb/tb_sprite_motion.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion.sv
// sprite_motion: per-frame position generator for N independent sprites.
// After each frame strobe (with run=1) a small FSM walks the channels, one
// channel per clock, stepping X and Y by the channel's speed. Each channel
// either bounces off or wraps around the travel bounds.
//
// Ports:
//   clk_pix   pixel clock
//   rst_pix   asynchronous active-high reset
//   frame     start-of-frame strobe (1 cycle)
//   run       1 = move on frame, 0 = hold positions
//   mode      per channel: 0 = bounce, 1 = wrap
//   spd_x/y   per-channel unsigned speed, channel i at [i*SPDW +: SPDW]
//   sprx/spry per-channel signed position, channel i at [i*CORDW +: CORDW]
//   dirx/diry per-channel direction: 0 = +, 1 = -
//   busy      update pass in progress (UPDATE or DONE)
//   done      1-cycle pulse at the end of a pass
//   overrun   sticky: frame arrived while busy
module sprite_motion #(
  parameter int CORDW     = 16,
  parameter int N         = 4,
  parameter int SPDW      = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPR_DRAWW = 64,
  parameter int SPR_DRAWH = 64,
  parameter int MARGIN    = 128
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               frame,
  input  logic               run,
  input  logic [N-1:0]       mode,
  input  logic [N*SPDW-1:0]  spd_x,
  input  logic [N*SPDW-1:0]  spd_y,
  output logic [N*CORDW-1:0] sprx,
  output logic [N*CORDW-1:0] spry,
  output logic [N-1:0]       dirx,
  output logic [N-1:0]       diry,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  // Bounds are kept one bit wider than a position so they compare directly
  // against the unclipped next position.
  localparam logic signed [CORDW:0] XL = (CORDW+1)'(-MARGIN);
  localparam logic signed [CORDW:0] XR = (CORDW+1)'(H_RES + MARGIN - SPR_DRAWW);
  localparam logic signed [CORDW:0] YL = (CORDW+1)'(-MARGIN);
  localparam logic signed [CORDW:0] YR = (CORDW+1)'(V_RES + MARGIN - SPR_DRAWH);

  localparam logic signed [CORDW-1:0] X_INIT = CORDW'(H_RES/2 - SPR_DRAWW/2);
  localparam logic signed [CORDW-1:0] Y_INIT = CORDW'(V_RES/2 - SPR_DRAWH/2);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic signed [CORDW-1:0] posx_q [N];
  logic signed [CORDW-1:0] posx_d [N];
  logic signed [CORDW-1:0] posy_q [N];
  logic signed [CORDW-1:0] posy_d [N];
  logic [N-1:0]            dirx_q, dirx_d;
  logic [N-1:0]            diry_q, diry_d;
  logic                    overrun_q, overrun_d;

  // One axis step. The sum is formed at CORDW+1 bits so that a step past a
  // bound is detected before it is clipped or wrapped. Landing exactly on a
  // bound is an ordinary move and keeps the direction.
  function automatic void axis_step(
    input  logic signed [CORDW-1:0] pos,
    input  logic                    dir,
    input  logic [SPDW-1:0]         spd,
    input  logic                    wrap,
    input  logic signed [CORDW:0]   lo,
    input  logic signed [CORDW:0]   hi,
    output logic signed [CORDW-1:0] pos_n,
    output logic                    dir_n
  );
    logic signed [CORDW:0] ext;
    logic signed [CORDW:0] sp;
    logic signed [CORDW:0] nxt;
    ext   = {pos[CORDW-1], pos};
    sp    = {{(CORDW+1-SPDW){1'b0}}, spd};
    nxt   = dir ? (ext - sp) : (ext + sp);
    pos_n = nxt[CORDW-1:0];
    dir_n = dir;
    if (!dir && (nxt > hi)) begin
      pos_n = wrap ? lo[CORDW-1:0] : hi[CORDW-1:0];
      dir_n = wrap ? dir : 1'b1;
    end else if (dir && (nxt < lo)) begin
      pos_n = wrap ? hi[CORDW-1:0] : lo[CORDW-1:0];
      dir_n = wrap ? dir : 1'b0;
    end
  endfunction

  // State and datapath registers; reset returns every channel to centre.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dirx_q    <= '0;
      diry_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        posx_q[i] <= X_INIT;
        posy_q[i] <= Y_INIT;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirx_q    <= dirx_d;
      diry_q    <= diry_d;
      overrun_q <= overrun_d;
      posx_q    <= posx_d;
      posy_q    <= posy_d;
    end
  end

  // Next-state logic. A frame seen while busy (including the DONE cycle) is
  // dropped and only flags overrun.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (frame && run) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (frame) overrun_d = 1'b1;
        if (idx_q == IDXW'(N-1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (frame) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Channel update: only the channel under the index changes, using the
  // mode and speeds present in its own update cycle.
  always_comb begin
    logic signed [CORDW-1:0] nx, ny;
    logic                    ndx, ndy;
    posx_d = posx_q;
    posy_d = posy_q;
    dirx_d = dirx_q;
    diry_d = diry_q;
    nx     = '0;
    ny     = '0;
    ndx    = 1'b0;
    ndy    = 1'b0;
    if (state_q == UPDATE) begin
      axis_step(posx_q[idx_q], dirx_q[idx_q], spd_x[int'(idx_q)*SPDW +: SPDW],
                mode[idx_q], XL, XR, nx, ndx);
      axis_step(posy_q[idx_q], diry_q[idx_q], spd_y[int'(idx_q)*SPDW +: SPDW],
                mode[idx_q], YL, YR, ny, ndy);
      posx_d[idx_q] = nx;
      posy_d[idx_q] = ny;
      dirx_d[idx_q] = ndx;
      diry_d[idx_q] = ndy;
    end
  end

  // Outputs decode directly from registers.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    overrun = overrun_q;
    dirx    = dirx_q;
    diry    = diry_q;
    for (int i = 0; i < N; i++) begin
      sprx[i*CORDW +: CORDW] = posx_q[i];
      spry[i*CORDW +: CORDW] = posy_q[i];
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// Testbench for sprite_motion with two channels. A table of single-cycle
// vectors covers the first pass, a mid-pass frame and the run=0 hold; hand
// sequences then cover asynchronous reset mid-pass and the bounce/wrap edges.
module tb_sprite_motion;

  localparam int N     = 2;
  localparam int CORDW = 16;
  localparam int SPDW  = 4;

  logic               clk_pix = 1'b0;
  logic               clk_on  = 1'b0;
  logic               rst_pix = 1'b0;
  logic               frame   = 1'b0;
  logic               run     = 1'b0;
  logic [N-1:0]       mode    = '0;
  logic [N*SPDW-1:0]  spd_x   = '0;
  logic [N*SPDW-1:0]  spd_y   = '0;
  logic [N*CORDW-1:0] sprx;
  logic [N*CORDW-1:0] spry;
  logic [N-1:0]       dirx;
  logic [N-1:0]       diry;
  logic               busy;
  logic               done;
  logic               overrun;

  int nvec = 0;
  int nerr = 0;

  sprite_motion #(
    .CORDW(CORDW), .N(N), .SPDW(SPDW), .H_RES(640), .V_RES(480),
    .SPR_DRAWW(64), .SPR_DRAWH(64), .MARGIN(128)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .run(run),
    .mode(mode), .spd_x(spd_x), .spd_y(spd_y), .sprx(sprx), .spry(spry),
    .dirx(dirx), .diry(diry), .busy(busy), .done(done), .overrun(overrun)
  );

  // Clock stays still until the no-clock reset check is done.
  always #5 if (clk_on) clk_pix = ~clk_pix;

  typedef struct {
    logic       frame;
    logic       run;
    logic [1:0] mode;
    logic [3:0] sx0, sy0, sx1, sy1;
    int         ex0, ey0, ex1, ey1;
    logic [1:0] edx, edy;
    logic       ebusy, edone, eovr;
  } vec_t;

  vec_t vecs [6];

  task automatic applyStimulus(input vec_t v);
    frame = v.frame;
    run   = v.run;
    mode  = v.mode;
    spd_x = {v.sx1, v.sx0};
    spd_y = {v.sy1, v.sy0};
  endtask

  task automatic checkField(input string name, input int got, input int want);
    if (got != want) begin
      nerr++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    logic signed [CORDW-1:0] x0, y0, x1, y1;
    x0 = sprx[CORDW-1:0];
    x1 = sprx[2*CORDW-1:CORDW];
    y0 = spry[CORDW-1:0];
    y1 = spry[2*CORDW-1:CORDW];
    nvec++;
    checkField({name, ".sprx0"},   int'(x0),      v.ex0);
    checkField({name, ".spry0"},   int'(y0),      v.ey0);
    checkField({name, ".sprx1"},   int'(x1),      v.ex1);
    checkField({name, ".spry1"},   int'(y1),      v.ey1);
    checkField({name, ".dirx"},    int'(dirx),    int'(v.edx));
    checkField({name, ".diry"},    int'(diry),    int'(v.edy));
    checkField({name, ".busy"},    int'(busy),    int'(v.ebusy));
    checkField({name, ".done"},    int'(done),    int'(v.edone));
    checkField({name, ".overrun"}, int'(overrun), int'(v.eovr));
  endtask

  task automatic checkState(input string name, input int ex0, input int ey0,
                            input int ex1, input int ey1,
                            input logic [1:0] edx, input logic [1:0] edy,
                            input logic eb, input logic ed, input logic eo);
    vec_t v;
    v = '{1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0,
          ex0, ey0, ex1, ey1, edx, edy, eb, ed, eo};
    checkOutput(v, name);
  endtask

  // One full pass from IDLE back to IDLE, with a bounded wait for done.
  task automatic doFrame(input logic [3:0] sx0, input logic [3:0] sy0,
                         input logic [3:0] sx1, input logic [3:0] sy1);
    frame = 1'b1;
    run   = 1'b1;
    spd_x = {sx1, sx0};
    spd_y = {sy1, sy0};
    @(negedge clk_pix);
    frame = 1'b0;
    for (int k = 0; k < 10 && !done; k++) @(negedge clk_pix);
    if (!done) begin
      nerr++;
      $display("[TB] FAIL frame_timeout: got done=%0d, want done=1", done);
    end
    @(negedge clk_pix);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with no clock ever toggled.
    #1 rst_pix = 1'b1;
    #1 checkState("reset_noclk", 288, 208, 288, 208, 2'b00, 2'b00, 0, 0, 0);
    clk_on = 1'b1;
    repeat (2) @(negedge clk_pix);
    rst_pix = 1'b0;
    run     = 1'b1;

    // Each vector: inputs for one cycle, outputs expected after that edge.
    vecs[0] = '{1'b1, 1'b1, 2'b00, 4'd4, 4'd2, 4'd0, 4'd0,
                288, 208, 288, 208, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b00, 4'd4, 4'd2, 4'd0, 4'd0,
                292, 210, 288, 208, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'b00, 4'd4, 4'd2, 4'd3, 4'd5,
                292, 210, 291, 213, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0,
                292, 210, 291, 213, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 4'd4, 4'd2, 4'd3, 4'd5,
                292, 210, 291, 213, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 4'd4, 4'd2, 4'd3, 4'd5,
                292, 210, 291, 213, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_pix);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted between edges in the middle of a pass.
    frame = 1'b1; run = 1'b1; mode = 2'b00;
    spd_x = {4'd0, 4'd5}; spd_y = {4'd0, 4'd5};
    @(negedge clk_pix);
    checkState("midpass_t1", 292, 210, 291, 213, 2'b00, 2'b00, 1, 0, 1);
    frame = 1'b0;
    @(negedge clk_pix);
    checkState("midpass_t2", 297, 215, 291, 213, 2'b00, 2'b00, 1, 0, 1);
    rst_pix = 1'b1;
    #1 checkState("reset_async", 288, 208, 288, 208, 2'b00, 2'b00, 0, 0, 0);
    #1 rst_pix = 1'b0;
    @(negedge clk_pix);

    // Clean pass after reset, checked cycle by cycle.
    frame = 1'b1;
    @(negedge clk_pix);
    checkState("clean_t1", 288, 208, 288, 208, 2'b00, 2'b00, 1, 0, 0);
    frame = 1'b0;
    @(negedge clk_pix);
    checkState("clean_t2", 293, 213, 288, 208, 2'b00, 2'b00, 1, 0, 0);
    @(negedge clk_pix);
    checkState("clean_t3", 293, 213, 288, 208, 2'b00, 2'b00, 1, 1, 0);
    @(negedge clk_pix);
    checkState("clean_t4", 293, 213, 288, 208, 2'b00, 2'b00, 0, 0, 0);

    // X edges: ch0 bounces, ch1 wraps.
    mode = 2'b10;
    repeat (27) doFrame(4'd15, 4'd0, 4'd15, 4'd0);
    doFrame(4'd4, 4'd0, 4'd9, 4'd0);
    checkState("near_xr", 702, 213, 702, 208, 2'b00, 2'b00, 0, 0, 0);
    doFrame(4'd4, 4'd0, 4'd4, 4'd0);
    checkState("xr_edge", 704, 213, -128, 208, 2'b01, 2'b00, 0, 0, 0);
    doFrame(4'd4, 4'd0, 4'd0, 4'd0);
    checkState("xr_back", 700, 213, -128, 208, 2'b01, 2'b00, 0, 0, 0);
    repeat (55) doFrame(4'd15, 4'd0, 4'd0, 4'd0);
    doFrame(4'd1, 4'd0, 4'd0, 4'd0);
    checkState("near_xl", -126, 213, -128, 208, 2'b01, 2'b00, 0, 0, 0);
    doFrame(4'd4, 4'd0, 4'd0, 4'd0);
    checkState("xl_bounce", -128, 213, -128, 208, 2'b00, 2'b00, 0, 0, 0);

    // Y edges on ch0: exact landing, bounce, then switch to wrap.
    repeat (22) doFrame(4'd0, 4'd15, 4'd0, 4'd0);
    doFrame(4'd0, 4'd1, 4'd0, 4'd0);
    checkState("yr_exact", -128, 544, -128, 208, 2'b00, 2'b00, 0, 0, 0);
    doFrame(4'd0, 4'd3, 4'd0, 4'd0);
    checkState("yr_bounce", -128, 544, -128, 208, 2'b00, 2'b01, 0, 0, 0);
    repeat (44) doFrame(4'd0, 4'd15, 4'd0, 4'd0);
    doFrame(4'd0, 4'd10, 4'd0, 4'd0);
    checkState("near_yl", -128, -126, -128, 208, 2'b00, 2'b01, 0, 0, 0);
    mode = 2'b11;
    doFrame(4'd0, 4'd4, 4'd0, 4'd0);
    checkState("yl_wrap", -128, 544, -128, 208, 2'b00, 2'b01, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
